systolic_feeder: RTL and testbench

//  Upstream sequencer for the 8x8 systolic array. Per job: loads 8 weight columns (one-hot load),

---
 rtl/systolic_feeder_pkg.sv | 14 +
 rtl/systolic_feeder_if.sv | 52 +++++
 rtl/systolic_feeder.sv | 117 +++++++++++
 tb/tb_systolic_feeder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and constants for the systolic array feeder: FSM states, array geometry, lane slicing.
package systolic_feeder_pkg;

   localparam int ARRAY_N = 8;
   localparam int DATA_W  = 8;
   localparam int BUS_W   = ARRAY_N * DATA_W;

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

   function automatic logic [DATA_W-1:0] lane(input logic [BUS_W-1:0] vec, input int i);
      return vec[DATA_W*i +: DATA_W];
   endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Job control, weight/activation buffer handshakes and array-side signals of the feeder.
// FEEDER_WEIGHT_REUSE_EN adds reuse_w (skip weight loading for a job).
interface systolic_feeder_if
   import systolic_feeder_pkg::*;
#(
   parameter int CNT_W = 9
) ();

   logic               start;
   logic               float_mode;
   logic [CNT_W-1:0]   num_rows;
`ifdef FEEDER_WEIGHT_REUSE_EN
   logic               reuse_w;
`endif
   logic [BUS_W-1:0]   w_data;
   logic               w_valid;
   logic               w_ready;
   logic [BUS_W-1:0]   a_data;
   logic               a_valid;
   logic               a_ready;
   logic [ARRAY_N-1:0] arr_load;
   logic [BUS_W-1:0]   arr_value;
   logic               arr_valid;
   logic               arr_float;
   logic               arr_out_valid;
   logic               arr_overflow;
   logic               busy;
   logic               done;
   logic               ovf;
   logic               timeout_err;

   modport master (
`ifdef FEEDER_WEIGHT_REUSE_EN
      output reuse_w,
`endif
      output start, float_mode, num_rows, w_data, w_valid, a_data, a_valid,
      output arr_out_valid, arr_overflow,
      input  w_ready, a_ready, arr_load, arr_value, arr_valid, arr_float,
      input  busy, done, ovf, timeout_err
   );

   modport slave (
`ifdef FEEDER_WEIGHT_REUSE_EN
      input  reuse_w,
`endif
      input  start, float_mode, num_rows, w_data, w_valid, a_data, a_valid,
      input  arr_out_valid, arr_overflow,
      output w_ready, a_ready, arr_load, arr_value, arr_valid, arr_float,
      output busy, done, ovf, timeout_err
   );

endinterface

// File: rtl/systolic_feeder.sv
// Upstream sequencer for the 8x8 systolic array: loads weight columns, streams activations, drains results.
// Optional FEEDER_WEIGHT_REUSE_EN: reuse_w at start skips LOAD_W and keeps the weights already in the array.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int CNT_W         = 9,
   parameter int DRAIN_TIMEOUT = 64
) (
   input logic               clk,
   input logic               n_rst,
   systolic_feeder_if.slave  bus
);

   localparam int COL_W  = $clog2(ARRAY_N);
   localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_cnt_q;
   logic [CNT_W-1:0]    in_cnt_q, out_cnt_q, rows_q;
   logic [IDLE_W-1:0]   idle_cnt_q;
   logic                float_q, ovf_q, tmo_q;
   logic [ARRAY_N-1:0]  arr_load_p1;
   logic [BUS_W-1:0]    arr_value_p1;
   logic                vld_p1;
   logic                start_acc, w_beat, a_beat, last_col, drain_quiet, drain_met;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] lim);
      return (cnt >= lim) ? cnt : cnt + CNT_W'(1);
   endfunction

   assign bus.w_ready = (state_q == LOAD_W);
   assign bus.a_ready = (state_q == STREAM) && (in_cnt_q < rows_q);

   assign start_acc   = (state_q == IDLE) && bus.start;
   assign w_beat      = bus.w_valid && bus.w_ready;
   assign a_beat      = bus.a_valid && bus.a_ready;
   assign last_col    = (col_cnt_q == COL_W'(ARRAY_N - 1));
   assign drain_met   = (out_cnt_q == rows_q);
   // Final quiet cycle: the counter already holds DRAIN_TIMEOUT-1 and this cycle is idle too.
   assign drain_quiet = (idle_cnt_q == IDLE_W'(DRAIN_TIMEOUT - 1)) && !bus.arr_out_valid;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD_W;
`ifdef FEEDER_WEIGHT_REUSE_EN
               if (bus.reuse_w) state_d = (bus.num_rows == '0) ? DONE : STREAM;
`endif
            end
         end
         LOAD_W: if (w_beat && last_col) state_d = (rows_q == '0) ? DONE : STREAM;
         STREAM: if (a_beat && (in_cnt_q == rows_q - CNT_W'(1))) state_d = DRAIN;
         DRAIN:  if (drain_met || drain_quiet) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         col_cnt_q    <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         rows_q       <= '0;
         idle_cnt_q   <= '0;
         float_q      <= 1'b0;
         ovf_q        <= 1'b0;
         tmo_q        <= 1'b0;
         arr_load_p1  <= '0;
         arr_value_p1 <= '0;
         vld_p1       <= 1'b0;
      end else begin
         state_q <= state_d;

         // p1: accepted beat is presented to the array one cycle later
         arr_load_p1  <= w_beat ? (ARRAY_N'(1) << col_cnt_q) : '0;
         arr_value_p1 <= w_beat ? bus.w_data : (a_beat ? bus.a_data : '0);
         vld_p1       <= a_beat;

         if (start_acc) begin
            rows_q     <= bus.num_rows;
            float_q    <= bus.float_mode;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            col_cnt_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            idle_cnt_q <= '0;
         end else begin
            if (w_beat) col_cnt_q <= col_cnt_q + COL_W'(1);
            if (a_beat) in_cnt_q  <= in_cnt_q + CNT_W'(1);
            if (bus.arr_out_valid && (state_q == STREAM || state_q == DRAIN))
               out_cnt_q <= sat_inc(out_cnt_q, rows_q);
            if (state_q == DRAIN)
               idle_cnt_q <= bus.arr_out_valid ? '0 : idle_cnt_q + IDLE_W'(1);
            if (bus.arr_overflow && (state_q == LOAD_W || state_q == STREAM || state_q == DRAIN))
               ovf_q <= 1'b1;
            if (state_q == DRAIN && !drain_met && drain_quiet)
               tmo_q <= 1'b1;
         end
      end
   end

   assign bus.arr_load    = arr_load_p1;
   assign bus.arr_value   = arr_value_p1;
   assign bus.arr_valid   = vld_p1;
   assign bus.arr_float   = float_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.ovf         = ovf_q;
   assign bus.timeout_err = (state_q == DONE) && tmo_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: job-level reference model checked every cycle plus literal spot checks.
module tb_systolic_feeder;
   import systolic_feeder_pkg::*;

   localparam int TB_CNT_W   = 9;
   localparam int TB_TIMEOUT = 64;
   localparam int P_IDLE = 0, P_LOAD = 1, P_STREAM = 2, P_DRAIN = 3, P_DONE = 4;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   n_vec  = 0;
   int   n_miss = 0;

   systolic_feeder_if #(.CNT_W(TB_CNT_W)) bus ();

   systolic_feeder #(.CNT_W(TB_CNT_W), .DRAIN_TIMEOUT(TB_TIMEOUT)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Job-level reference: what the feeder owes the array and the caller, cycle by cycle.
   int          m_phase, m_rows, m_cols, m_sent, m_back, m_quiet;
   logic        m_float, m_ovf, m_tmo, m_reuse, m_wbeat, m_abeat;
   logic [7:0]  e_load;
   logic [63:0] e_value;
   logic        e_valid;

`ifdef FEEDER_WEIGHT_REUSE_EN
   assign m_reuse = bus.reuse_w;
`else
   assign m_reuse = 1'b0;
`endif
   assign m_wbeat = bus.w_valid && (m_phase == P_LOAD);
   assign m_abeat = bus.a_valid && (m_phase == P_STREAM) && (m_sent < m_rows);

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_phase <= P_IDLE; m_rows <= 0; m_cols <= 0; m_sent <= 0; m_back <= 0; m_quiet <= 0;
         m_float <= 1'b0; m_ovf <= 1'b0; m_tmo <= 1'b0;
         e_load <= '0; e_value <= '0; e_valid <= 1'b0;
      end else begin
         e_load  <= m_wbeat ? 8'(1 << m_cols) : 8'h00;
         e_value <= m_wbeat ? bus.w_data : (m_abeat ? bus.a_data : 64'h0);
         e_valid <= m_abeat;
         if (bus.arr_overflow && m_phase >= P_LOAD && m_phase <= P_DRAIN) m_ovf <= 1'b1;
         if (bus.arr_out_valid && (m_phase == P_STREAM || m_phase == P_DRAIN) && m_back < m_rows)
            m_back <= m_back + 1;
         case (m_phase)
            P_IDLE: if (bus.start) begin
               m_rows <= int'(bus.num_rows); m_float <= bus.float_mode;
               m_ovf <= 1'b0; m_tmo <= 1'b0;
               m_cols <= 0; m_sent <= 0; m_back <= 0; m_quiet <= 0;
               if (!m_reuse) m_phase <= P_LOAD;
               else          m_phase <= (bus.num_rows == 0) ? P_DONE : P_STREAM;
            end
            P_LOAD: if (m_wbeat) begin
               m_cols <= m_cols + 1;
               if (m_cols == ARRAY_N - 1) m_phase <= (m_rows == 0) ? P_DONE : P_STREAM;
            end
            P_STREAM: if (m_abeat) begin
               m_sent <= m_sent + 1;
               if (m_sent + 1 == m_rows) m_phase <= P_DRAIN;
            end
            P_DRAIN: begin
               if (m_back == m_rows) m_phase <= P_DONE;
               else if (bus.arr_out_valid) m_quiet <= 0;
               else if (m_quiet + 1 == TB_TIMEOUT) begin m_phase <= P_DONE; m_tmo <= 1'b1; end
               else m_quiet <= m_quiet + 1;
            end
            P_DONE: m_phase <= P_IDLE;
            default: m_phase <= P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("w_ready",   64'(bus.w_ready),   64'(m_phase == P_LOAD));
      chk("a_ready",   64'(bus.a_ready),   64'(m_phase == P_STREAM && m_sent < m_rows));
      chk("arr_load",  64'(bus.arr_load),  64'(e_load));
      chk("arr_value", bus.arr_value,      e_value);
      chk("arr_valid", 64'(bus.arr_valid), 64'(e_valid));
      chk("busy",      64'(bus.busy),      64'(m_phase != P_IDLE));
      chk("done",      64'(bus.done),      64'(m_phase == P_DONE));
      chk("ovf",       64'(bus.ovf),       64'(m_ovf));
      if (m_phase != P_IDLE) chk("arr_float",   64'(bus.arr_float),   64'(m_float));
      if (m_phase == P_DONE) chk("timeout_err", 64'(bus.timeout_err), 64'(m_tmo));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int rows, input logic fm, input logic reuse);
      bus.start = 1'b1; bus.num_rows = TB_CNT_W'(rows); bus.float_mode = fm;
`ifdef FEEDER_WEIGHT_REUSE_EN
      bus.reuse_w = reuse;
`else
      if (reuse) $display("note: reuse_w not built in");
`endif
      tick();
      bus.start = 1'b0;
`ifdef FEEDER_WEIGHT_REUSE_EN
      bus.reuse_w = 1'b0;
`endif
   endtask

   task automatic load_weights();
      bus.w_valid = 1'b1;
      for (int k = 0; k < ARRAY_N; k++) begin
         bus.w_data = 64'h0101010101010101 * 64'(k + 1);
         tick();
      end
      bus.w_valid = 1'b0;
   endtask

   task automatic stream_rows(input int n);
      bus.a_valid = 1'b1;
      for (int r = 0; r < n; r++) begin
         bus.a_data = 64'hA0A0A0A0A0A0A0A0 + 64'(r);
         tick();
      end
      bus.a_valid = 1'b0;
   endtask

   task automatic pulses(input int n);
      bus.arr_out_valid = 1'b1;
      repeat (n) tick();
      bus.arr_out_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      while (!bus.done && cycles < budget) begin
         tick();
         cycles++;
      end
      chk("wait_done", 64'(bus.done), 64'd1);
   endtask

   initial begin
      int n;
      bus.start = 1'b0; bus.float_mode = 1'b0; bus.num_rows = '0;
      bus.w_data = '0; bus.w_valid = 1'b0; bus.a_data = '0; bus.a_valid = 1'b0;
      bus.arr_out_valid = 1'b0; bus.arr_overflow = 1'b0;
`ifdef FEEDER_WEIGHT_REUSE_EN
      bus.reuse_w = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_load", 64'(bus.arr_load), 64'd0);
      n_rst = 1'b1;
      tick();

      // 1: full job, 3 rows, data always valid
      do_start(3, 1'b1, 1'b0);
      chk("t1_float", 64'(bus.arr_float), 64'd1);
      bus.w_valid = 1'b1;
      bus.a_valid = 1'b1;
      for (int k = 0; k < ARRAY_N; k++) begin
         bus.w_data = 64'h0101010101010101 * 64'(k + 1);
         tick();
         chk("t1_load", 64'(bus.arr_load), 64'(8'h01 << k));
         chk("t1_lane", 64'(lane(bus.arr_value, 3)), 64'(k + 1));
      end
      bus.w_valid = 1'b0;
      stream_rows(3);
      chk("t1_last_row", bus.arr_value, 64'hA0A0A0A0A0A0A0A2);
      pulses(3);
      tick();
      chk("t1_done", 64'(bus.done), 64'd1);
      chk("t1_tmo", 64'(bus.timeout_err), 64'd0);
      tick();
      chk("t1_busy_fall", 64'(bus.busy), 64'd0);

      // 2: activation bubbles
      do_start(3, 1'b0, 1'b0);
      load_weights();
      for (int i = 0; i < 5; i++) begin
         bus.a_valid = (i % 2 == 0);
         bus.a_data  = 64'h5500000000000000 + 64'(i);
         tick();
         chk("t2_valid", 64'(bus.arr_valid), 64'(i % 2 == 0));
      end
      chk("t2_a_ready_low", 64'(bus.a_ready), 64'd0);
      bus.a_valid = 1'b1;
      tick();
      chk("t2_no_4th", 64'(bus.arr_valid), 64'd0);
      bus.a_valid = 1'b0;
      pulses(3);
      wait_done(4, n);

      // 3: zero-row job
      tick();
      do_start(0, 1'b0, 1'b0);
      load_weights();
      chk("t3_done", 64'(bus.done), 64'd1);
      tick();

      // 4: drain timeout from DRAIN entry
      do_start(2, 1'b0, 1'b0);
      load_weights();
      stream_rows(2);
      wait_done(200, n);
      chk("t4_latency", 64'(n), 64'(TB_TIMEOUT));
      chk("t4_tmo", 64'(bus.timeout_err), 64'd1);
      tick();

      // 5: overflow sticky, start while busy ignored
      do_start(1, 1'b1, 1'b0);
      bus.start = 1'b1; bus.num_rows = TB_CNT_W'(5);
      tick();
      bus.start = 1'b0;
      load_weights();
      bus.a_valid = 1'b1; bus.arr_overflow = 1'b1;
      tick();
      bus.a_valid = 1'b0; bus.arr_overflow = 1'b0;
      chk("t5_ovf_set", 64'(bus.ovf), 64'd1);
      chk("t5_a_ready", 64'(bus.a_ready), 64'd0);
      pulses(1);
      tick();
      chk("t5_done", 64'(bus.done), 64'd1);
      chk("t5_ovf_done", 64'(bus.ovf), 64'd1);
      tick();
      tick();
      chk("t5_ovf_held", 64'(bus.ovf), 64'd1);

      // 6: reset mid-stream
      do_start(4, 1'b0, 1'b0);
      chk("t5_ovf_clr", 64'(bus.ovf), 64'd0);
      load_weights();
      stream_rows(2);
      n_rst = 1'b0;
      #1;
      chk("t6_busy", 64'(bus.busy), 64'd0);
      chk("t6_value", bus.arr_value, 64'd0);
      chk("t6_valid", 64'(bus.arr_valid), 64'd0);
      chk("t6_a_ready", 64'(bus.a_ready), 64'd0);
      repeat (2) tick();
      chk("t6_no_done", 64'(bus.done), 64'd0);
      n_rst = 1'b1;
      tick();
`ifdef FEEDER_WEIGHT_REUSE_EN
      do_start(2, 1'b0, 1'b1);
      chk("t6_reuse_w_ready", 64'(bus.w_ready), 64'd0);
      chk("t6_reuse_a_ready", 64'(bus.a_ready), 64'd1);
      stream_rows(2);
      pulses(2);
      wait_done(4, n);
      tick();
`endif
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
